// File: rtl/uctl_memrdarbiter.sv
`default_nettype none
// ============================================================================
// Module      : uctl_memrdarbiter
// Description : Round-robin memory1 read arbiter (sepr/dmaRx/cmd) with tag
//               FIFO routing of in-order return data.
// Revision    : 1.0 - initial release
// ============================================================================
module uctl_memrdarbiter #(
    parameter int ADDR_SIZE       = 32,
    parameter int DATA_SIZE       = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_MAX       = 4
) (
    input  logic                 coreClk,
    input  logic                 coreRst,
    input  logic                 sepr2arb_rd,
    input  logic                 dmaRx2arb_rdReq,
    input  logic                 cmd2arb_rdReq,
    input  logic [ADDR_SIZE-1:0] sepr2arb_addr,
    input  logic [ADDR_SIZE-1:0] dmaRx2arb_addr,
    input  logic [ADDR_SIZE-1:0] cmd2arb_addr,
    output logic                 arb2sepr_ack,
    output logic                 arb2dmaRx_ack,
    output logic                 arb2cmd_ack,
    output logic                 arb2sepr_rdVal,
    output logic                 arb2dmaRx_rdVal,
    output logic                 arb2cmd_rdVal,
    output logic [DATA_SIZE-1:0] arb2sepr_rdData,
    output logic [DATA_SIZE-1:0] arb2dmaRx_rdData,
    output logic [DATA_SIZE-1:0] arb2cmd_rdData,
    output logic                 mem1_rd,
    output logic [ADDR_SIZE-1:0] mem1_addr,
    input  logic                 mem1_ackOut,
    input  logic                 mem1_dataVld,
    input  logic [DATA_SIZE-1:0] mem1_dataOut,
    output logic                 arb_tagErr,
    output logic                 arb_busy
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(BURST_MAX) + 1;

    localparam logic [BC_W-1:0]  c_burst_last = BC_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] c_fifo_full  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [0:0]       c_idle       = 1'b0;
    localparam logic [0:0]       c_grant      = 1'b1;

    logic [0:0]       r_state_q,     w_state_d;
    logic [1:0]       r_grant_idx_q, w_grant_idx_d;
    logic [1:0]       r_last_idx_q,  w_last_idx_d;
    logic [BC_W-1:0]  r_burst_cnt_q, w_burst_cnt_d;
    logic [PTR_W-1:0] r_wr_ptr_q,    w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q,    w_rd_ptr_d;
    logic [CNT_W-1:0] r_fifo_cnt_q,  w_fifo_cnt_d;
    logic             r_tag_err_q,   w_tag_err_d;
    logic [1:0]       r_tag_mem_q [MAX_OUTSTANDING];

    logic [2:0]           w_req;
    logic                 w_gnt_req;
    logic [ADDR_SIZE-1:0] w_gnt_addr;
    logic [1:0]           w_cand1, w_cand2, w_sel_idx, w_head;
    logic                 w_fifo_full, w_fifo_empty;
    logic                 w_mem_rd, w_accept, w_pop;

    assign w_req        = {cmd2arb_rdReq, dmaRx2arb_rdReq, sepr2arb_rd};
    assign w_fifo_full  = (r_fifo_cnt_q == c_fifo_full);
    assign w_fifo_empty = (r_fifo_cnt_q == '0);
    assign w_accept     = w_mem_rd & mem1_ackOut;
    assign w_pop        = mem1_dataVld & ~w_fifo_empty;
    assign w_head       = r_tag_mem_q[r_rd_ptr_q];

    // Circular search order: last+1, last+2, last (indices modulo 3)
    assign w_cand1 = (r_last_idx_q == 2'd2) ? 2'd0 : r_last_idx_q + 2'd1;
    assign w_cand2 = (w_cand1 == 2'd2) ? 2'd0 : w_cand1 + 2'd1;

    always_comb begin
        w_sel_idx = r_last_idx_q;
        if (w_req[w_cand1]) begin
            w_sel_idx = w_cand1;
        end else if (w_req[w_cand2]) begin
            w_sel_idx = w_cand2;
        end
    end

    always_comb begin
        w_gnt_req  = 1'b0;
        w_gnt_addr = '0;
        case (r_grant_idx_q)
            2'd0:    begin w_gnt_req = sepr2arb_rd;     w_gnt_addr = sepr2arb_addr;  end
            2'd1:    begin w_gnt_req = dmaRx2arb_rdReq; w_gnt_addr = dmaRx2arb_addr; end
            2'd2:    begin w_gnt_req = cmd2arb_rdReq;   w_gnt_addr = cmd2arb_addr;   end
            default: begin w_gnt_req = 1'b0;            w_gnt_addr = '0;             end
        endcase
    end

    always_ff @(posedge coreClk) begin
        if (coreRst) begin
            r_state_q     <= c_idle;
            r_grant_idx_q <= 2'd0;
            r_last_idx_q  <= 2'd2;
            r_burst_cnt_q <= '0;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_fifo_cnt_q  <= '0;
            r_tag_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_grant_idx_q <= w_grant_idx_d;
            r_last_idx_q  <= w_last_idx_d;
            r_burst_cnt_q <= w_burst_cnt_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_fifo_cnt_q  <= w_fifo_cnt_d;
            r_tag_err_q   <= w_tag_err_d;
        end
    end

    // Tag storage needs no reset: validity is tracked by the count/pointers
    always_ff @(posedge coreClk) begin
        if (w_accept) begin
            r_tag_mem_q[r_wr_ptr_q] <= r_grant_idx_q;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_grant_idx_d = r_grant_idx_q;
        w_last_idx_d  = r_last_idx_q;
        w_burst_cnt_d = r_burst_cnt_q;
        case (r_state_q)
            c_idle: begin
                if ((|w_req) && !w_fifo_full) begin
                    w_grant_idx_d = w_sel_idx;
                    w_last_idx_d  = w_sel_idx;
                    w_burst_cnt_d = '0;
                    w_state_d     = c_grant;
                end
            end
            c_grant: begin
                if (w_accept) begin
                    w_burst_cnt_d = r_burst_cnt_q + BC_W'(1);
                end
                if ((w_accept && (r_burst_cnt_q == c_burst_last)) || !w_gnt_req ||
                    (w_fifo_full && !w_accept)) begin
                    w_state_d = c_idle;
                end
            end
            default: w_state_d = c_idle;
        endcase
    end

    always_comb begin
        w_mem_rd      = (r_state_q == c_grant) & w_gnt_req & ~w_fifo_full;
        mem1_rd       = w_mem_rd;
        mem1_addr     = w_mem_rd ? w_gnt_addr : '0;
        arb2sepr_ack  = w_accept & (r_grant_idx_q == 2'd0);
        arb2dmaRx_ack = w_accept & (r_grant_idx_q == 2'd1);
        arb2cmd_ack   = w_accept & (r_grant_idx_q == 2'd2);
        arb_busy      = (r_state_q == c_grant) | ~w_fifo_empty;
    end

    always_comb begin
        w_wr_ptr_d   = w_accept ? r_wr_ptr_q + PTR_W'(1) : r_wr_ptr_q;
        w_rd_ptr_d   = w_pop ? r_rd_ptr_q + PTR_W'(1) : r_rd_ptr_q;
        w_fifo_cnt_d = r_fifo_cnt_q;
        if (w_accept && !w_pop) begin
            w_fifo_cnt_d = r_fifo_cnt_q + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            w_fifo_cnt_d = r_fifo_cnt_q - CNT_W'(1);
        end
        w_tag_err_d = r_tag_err_q | (mem1_dataVld & w_fifo_empty);
    end

    // Return data is steered to the head tag with zero added latency
    always_comb begin
        arb2sepr_rdVal   = w_pop & (w_head == 2'd0);
        arb2dmaRx_rdVal  = w_pop & (w_head == 2'd1);
        arb2cmd_rdVal    = w_pop & (w_head == 2'd2);
        arb2sepr_rdData  = arb2sepr_rdVal  ? mem1_dataOut : '0;
        arb2dmaRx_rdData = arb2dmaRx_rdVal ? mem1_dataOut : '0;
        arb2cmd_rdData   = arb2cmd_rdVal   ? mem1_dataOut : '0;
        arb_tagErr       = r_tag_err_q;
    end

endmodule
`default_nettype wire

// File: doc/uctl_memrdarbiter.md
# uctl_memRdArbiter

Round-robin read arbiter for the local-buffer memory1 read port, shared by the system endpoint receive path (sepr), the DMA Rx engine (dmaRx) and the command memory interface (cmd). It grants the port to one requester at a time, allows bounded back-to-back reads per grant, and tags every accepted read. It routes in-order return data (mem1_dataVld/mem1_dataOut) back to the originating requester through a tag FIFO, so a requester may drop its request while data is still in flight.

## Interface
- ADDR_SIZE, 32, address width
- DATA_SIZE, 32, data width
- MAX_OUTSTANDING, 4, tag FIFO depth (max accepted-but-unreturned reads), power of two, ≥2
- BURST_MAX, 4, max consecutive accepted reads per grant, ≥1

- coreClk  input  1  core clock; all logic on rising edge
- coreRst  input  1  synchronous, active-high reset
- sepr2arb_rd / dmaRx2arb_rdReq / cmd2arb_rdReq  input  1 each  read requests, index 0/1/2
- sepr2arb_addr / dmaRx2arb_addr / cmd2arb_addr  input  ADDR_SIZE each  read addresses
- arb2sepr_ack / arb2dmaRx_ack / arb2cmd_ack  output  1 each  read accepted
- arb2sepr_rdVal / arb2dmaRx_rdVal / arb2cmd_rdVal  output  1 each  return data valid
- arb2sepr_rdData / arb2dmaRx_rdData / arb2cmd_rdData  output  DATA_SIZE each  return data; zero when matching rdVal low
- mem1_rd  output  1  read strobe to memory1
- mem1_addr  output  ADDR_SIZE  read address; zero when mem1_rd low
- mem1_ackOut  input  1  memory accepts the read this cycle
- mem1_dataVld  input  1  return data valid; returns in issue order, ≥1 cycle after accept
- mem1_dataOut  input  DATA_SIZE  return data
- arb_tagErr  output  1  sticky: mem1_dataVld seen with tag FIFO empty
- arb_busy  output  1  state is GRANT or tag FIFO non-empty

## Operation
- Requester protocol: hold req and addr stable until ack. Each ack cycle is one accepted read. The requester may change addr and keep req high for the next read.
- FSM states are IDLE and GRANT. Registers: grantIdx[1:0], lastIdx[1:0], burstCnt, tag FIFO (2-bit entries), fifoCnt.
- IDLE: if any req is high and the FIFO is not full, select the first requester in circular order lastIdx+1, lastIdx+2, lastIdx. Load grantIdx and set lastIdx to the selected index. Clear burstCnt and go to GRANT.
- GRANT: mem1_rd = req[grantIdx] & ~fifoFull; mem1_addr = addr[grantIdx].
  - ack[grantIdx] = mem1_rd & mem1_ackOut, combinational. All other acks are 0.
  - On accept: push grantIdx into the FIFO and increment burstCnt.
  - Return to IDLE when any of these holds:
    - an accept occurs with burstCnt+1 == BURST_MAX;
    - req[grantIdx] is low;
    - fifoFull and no accept this cycle.
- Return path: when mem1_dataVld is high and the FIFO is non-empty, pop the head. Assert rdVal for the head tag and drive its rdData = mem1_dataOut, combinational. Other rdVal are 0 and other rdData are zero.
- Empty-FIFO return: mem1_dataVld with the FIFO empty drops the data, drives no rdVal, and sets arb_tagErr. arb_tagErr clears only on reset.
- Simultaneous push and pop: fifoCnt is unchanged and both operations take effect. Full is evaluated on the registered fifoCnt (== MAX_OUTSTANDING), so no combinational path exists from mem1_dataVld to mem1_rd.
- fifoCnt width is clog2(MAX_OUTSTANDING)+1. Read and write pointers are clog2(MAX_OUTSTANDING) bits and wrap naturally.

## Timing
- Reset (coreRst sampled high): state = IDLE, lastIdx = 2 (so index 0 is first), burstCnt = 0, fifoCnt = 0, pointers = 0, arb_tagErr = 0.
- Output reset values: all acks, rdVals, mem1_rd and arb_busy are 0; all data and address outputs are zero.
- Reset mid-operation: in-flight tags are discarded. Memory1 is reset by the same reset, so no stale returns are expected; any stale return sets arb_tagErr.
- Grant latency: req rises at cycle N in IDLE → mem1_rd high at cycle N+1. With mem1_ackOut high at N+1, ack is high at N+1.
- Sustained single requester with mem1_ackOut always high: BURST_MAX accepts on consecutive cycles, then one IDLE bubble cycle, then the next grant.
- Return routing adds zero latency: rdVal is in the same cycle as mem1_dataVld.
- The memory may hold mem1_ackOut low for any number of cycles. The grant persists while req stays high.

## Test plan
- Single read: sepr2arb_rd high, addr 0x10, mem1_ackOut same cycle, mem1_dataVld 2 cycles later with 0xA5A5_0001 → mem1_rd at cycle 1, arb2sepr_ack at cycle 1, arb2sepr_rdVal with 0xA5A5_0001 at cycle 3, and no other rdVal.
- Round-robin: all three requesters continuously requesting, BURST_MAX=1, memory always acking → grant order 0,1,2,0,1,2 with one IDLE cycle between grants; each returned datum goes to the requester that issued it.
- Burst limit: dmaRx requesting alone with BURST_MAX=4 → 4 consecutive acks, addresses 0x20..0x23 as driven, a 1-cycle gap, then 4 more acks.
- FIFO full: memory acks but withholds data, MAX_OUTSTANDING=4 → exactly 4 accepts, then mem1_rd low and arb_busy high. One dataVld pop → the next accept occurs on a following cycle and fifoCnt returns to 4.
- Spurious return: mem1_dataVld with the FIFO empty → no rdVal asserted, arb_tagErr goes high and stays high until coreRst.
- Reset mid-burst: coreRst high during GRANT with 3 tags outstanding → next cycle all outputs are at reset values and fifoCnt = 0. After reset, requester 0 wins the first arbitration against simultaneous requests.
